// File: rtl/sample_framer_pkg.sv
//----------------------------------------------------------------------------
// Module : sample_framer_pkg
// Brief  : Shared state encoding and default widths for the sample framer.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package sample_framer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_LEN_WIDTH  = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  function automatic logic is_capture_state(input state_t st);
    return (st == ST_RUN) || (st == ST_FINISH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
//----------------------------------------------------------------------------
// Module : sample_fifo
// Brief  : Synchronous first-word-fall-through FIFO with full/empty flags.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sample_fifo
  import sample_framer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_framer.sv
//----------------------------------------------------------------------------
// Module : sample_framer
// Brief  : Packs a strobed sample stream into fixed-length AXI4-Stream frames.
//          Optional first-beat tuser flag enabled by SAMPLE_FRAMER_TUSER_EN.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  cfg_enable,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
`ifdef SAMPLE_FRAMER_TUSER_EN
  output logic                  m_axis_tuser,
`endif
  output logic                  overflow,
  output logic [31:0]           frame_count
);

`ifdef SAMPLE_FRAMER_TUSER_EN
  localparam int unsigned PW = DATA_WIDTH + 2;
`else
  localparam int unsigned PW = DATA_WIDTH + 1;
`endif
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_m1_q, len_m1_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          frame_count_q, frame_count_d;

  logic                 fifo_wr_en;
  logic [PW-1:0]        fifo_wr_data;
  logic [PW-1:0]        fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 rd_en;
  logic                 is_last;
  logic                 drop;

  assign is_last = (cnt_q == len_m1_q);
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign drop    = is_capture_state(state_q) && s_valid && fifo_full && !rd_en;

`ifdef SAMPLE_FRAMER_TUSER_EN
  assign fifo_wr_data = {(cnt_q == '0), is_last, s_data};
  assign m_axis_tuser = !fifo_empty && fifo_rd_data[DATA_WIDTH+1];
`else
  assign fifo_wr_data = {is_last, s_data};
`endif

  always_comb begin
    state_d    = state_q;
    len_m1_d   = len_m1_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    fifo_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          len_m1_d = (cfg_len == '0) ? '0 : (cfg_len - LEN_ONE);
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN, ST_FINISH: begin
        if (drop) begin
          overflow_d = 1'b1;
          state_d    = ST_DRAIN;
        end else begin
          if (s_valid) begin
            fifo_wr_en = 1'b1;
            cnt_d      = is_last ? '0 : (cnt_q + LEN_ONE);
          end
          // Stopping on a frame boundary needs no FINISH phase.
          if (state_q == ST_RUN) begin
            if (!cfg_enable) begin
              state_d = (cnt_d == '0) ? ST_DRAIN : ST_FINISH;
            end
          end else if (s_valid && is_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_count_d = frame_count_q;
    if (rd_en && m_axis_tlast) begin
      frame_count_d = frame_count_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_m1_q      <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      len_m1_q      <= len_m1_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  sample_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (aclk),
    .rst_i     (reset),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i (fifo_wr_data),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Outputs are forced to zero whenever nothing is queued.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rd_data[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_rd_data[DATA_WIDTH];
  assign overflow      = overflow_q;
  assign frame_count   = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_framer.sv
//----------------------------------------------------------------------------
// Module : tb_sample_framer
// Brief  : Directed vector bench for sample_framer.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_sample_framer;
  import sample_framer_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FD = 16;

  logic          aclk = 1'b0;
  logic          reset;
  logic          cfg_enable;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
`ifdef SAMPLE_FRAMER_TUSER_EN
  logic          m_axis_tuser;
`endif
  logic          overflow;
  logic [31:0]   frame_count;

  sample_framer #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .cfg_len       (cfg_len),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
`ifdef SAMPLE_FRAMER_TUSER_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .overflow      (overflow),
    .frame_count   (frame_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t beats[$];
  logic        stall_q = 1'b0;
  logic [DW:0] stall_val;
  int          stall_err = 0;
  int          checks = 0;
  int          errors = 0;

  // Inputs settle at posedge+1, so negedge values are what the next edge sees.
  always @(negedge aclk) begin
    if (stall_q && !(m_axis_tvalid && ({m_axis_tdata, m_axis_tlast} == stall_val)))
      stall_err++;
    if (m_axis_tvalid && m_axis_tready)
      beats.push_back('{data: m_axis_tdata, last: m_axis_tlast});
    stall_q   = m_axis_tvalid && !m_axis_tready && !reset;
    stall_val = {m_axis_tdata, m_axis_tlast};
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    cfg_enable    = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    beats.delete();
  endtask

  // Summarise collected beats: tlast mask (first 32), tlast count, order errors.
  task automatic scan_beats(output logic [31:0] mask, output int lasts, output int bad);
    mask  = '0;
    lasts = 0;
    bad   = 0;
    for (int j = 0; j < beats.size(); j++) begin
      if (beats[j].last) begin
        lasts++;
        if (j < 32) mask[j] = 1'b1;
      end
      if (beats[j].data != DW'(j + 1)) bad++;
    end
  endtask

  typedef struct {
    logic [LW-1:0] len;
    int            nsamp;
    int            dis_after;
    int            exp_beats;
    logic [31:0]   exp_mask;
    int            exp_frames;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] mask;
    int          lasts;
    int          bad;
    int          sent;

    vecs[0] = '{16'd4, 12, 0, 12, 32'h0000_0888, 3};
    vecs[1] = '{16'd0,  5, 0,  5, 32'h0000_001F, 5};
    vecs[2] = '{16'd8, 12, 3,  8, 32'h0000_0080, 1};
    vecs[3] = '{16'd1,  3, 0,  3, 32'h0000_0007, 3};
    vecs[4] = '{16'd3,  7, 0,  7, 32'h0000_0024, 2};
    vecs[5] = '{16'd5, 10, 5, 10, 32'h0000_0210, 2};

    cfg_len = '0;
    do_reset();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_state", dut.state_q, ST_IDLE);

    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    m_axis_tready = 1'b1;
    repeat (4) tick();
    check("idle_ignores_valid", m_axis_tvalid, 0);
    check("idle_no_beats", beats.size(), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      m_axis_tready = 1'b1;
      cfg_len       = vecs[v].len;
      cfg_enable    = 1'b1;
      tick();
      for (int i = 1; i <= vecs[v].nsamp; i++) begin
        s_valid = 1'b1;
        s_data  = DW'(i);
        if (vecs[v].dis_after != 0 && i > vecs[v].dis_after) cfg_enable = 1'b0;
        tick();
      end
      s_valid    = 1'b0;
      cfg_enable = 1'b0;
      repeat (40) tick();
      scan_beats(mask, lasts, bad);
      check($sformatf("v%0d_beats", v), beats.size(), vecs[v].exp_beats);
      check($sformatf("v%0d_tlast_mask", v), mask, vecs[v].exp_mask);
      check($sformatf("v%0d_data_order", v), bad, 0);
      check($sformatf("v%0d_frame_count", v), frame_count, vecs[v].exp_frames);
      check($sformatf("v%0d_overflow", v), overflow, 0);
    end

    // Overflow: 17 samples into a 16-deep FIFO with the sink stalled.
    do_reset();
    cfg_len    = 16'd100;
    cfg_enable = 1'b1;
    tick();
    for (int i = 1; i <= 17; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
    end
    s_valid    = 1'b0;
    cfg_enable = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_state_drain", dut.state_q, ST_DRAIN);
    m_axis_tready = 1'b1;
    repeat (40) tick();
    scan_beats(mask, lasts, bad);
    check("ovf_beats", beats.size(), 16);
    check("ovf_no_tlast", lasts, 0);
    check("ovf_data_order", bad, 0);
    check("ovf_state_idle", dut.state_q, ST_IDLE);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with a simultaneous read accepts the write.
    do_reset();
    cfg_len    = 16'd100;
    cfg_enable = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
    end
    s_data        = DW'(17);
    m_axis_tready = 1'b1;
    tick();
    s_valid    = 1'b0;
    cfg_enable = 1'b0;
    check("full_rw_no_overflow", overflow, 0);
    repeat (30) tick();
    scan_beats(mask, lasts, bad);
    check("full_rw_beats", beats.size(), 17);
    check("full_rw_data_order", bad, 0);

    // Random backpressure, source throttled to keep the FIFO from filling.
    do_reset();
    stall_err  = 0;
    cfg_len    = 16'd3;
    cfg_enable = 1'b1;
    tick();
    sent = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 300 || beats.size() < 300); cyc++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      if (sent < 300 && (sent - beats.size()) < 10) begin
        sent++;
        s_valid = 1'b1;
        s_data  = DW'(sent);
      end else begin
        s_valid = 1'b0;
      end
      if (sent == 300 && !s_valid) cfg_enable = 1'b0;
      tick();
    end
    s_valid       = 1'b0;
    cfg_enable    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (5) tick();
    scan_beats(mask, lasts, bad);
    check("rnd_beats", beats.size(), 300);
    check("rnd_tlast_count", lasts, 100);
    check("rnd_data_order", bad, 0);
    check("rnd_frame_count", frame_count, 100);
    check("rnd_overflow", overflow, 0);
    check("rnd_stall_stable", stall_err, 0);
    check("rnd_state_idle", dut.state_q, ST_IDLE);

    // Reset mid-frame with five beats queued.
    m_axis_tready = 1'b0;
    cfg_len       = 16'd8;
    cfg_enable    = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(100 + i);
      tick();
    end
    s_valid = 1'b0;
    check("mid_queued", m_axis_tvalid, 1);
    reset      = 1'b1;
    cfg_enable = 1'b0;
    tick();
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_frame_count", frame_count, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    reset = 1'b0;
    beats.delete();
    m_axis_tready = 1'b1;
    cfg_len       = 16'd4;
    cfg_enable    = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
    end
    s_valid    = 1'b0;
    cfg_enable = 1'b0;
    repeat (20) tick();
    scan_beats(mask, lasts, bad);
    check("post_rst_beats", beats.size(), 4);
    check("post_rst_tlast_mask", mask, 32'h8);
    check("post_rst_data_order", bad, 0);
    check("post_rst_frame_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: sample and AXI-Stream tdata width; matches the selected-channel width from the four-way channel selector it follows.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the frame-length configuration.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: FIFO entries; power of two, at least 4.
REQ-004 SHALL have port aclk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cfg_enable, input, 1 bit: capture enable (level).
REQ-007 SHALL have port cfg_len, input, LEN_WIDTH bits: samples per frame; the value 0 is treated as 1.
REQ-008 SHALL have port s_data, input, DATA_WIDTH bits: the selected-channel sample.
REQ-009 SHALL have port s_valid, input, 1 bit: sample strobe; there is no backpressure toward the source.
REQ-010 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), forming an AXI4-Stream master.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag set when a sample is dropped because the FIFO was full.
REQ-012 SHALL have port frame_count, output, 32 bits: number of completed frames, wrapping modulo 2^32.

Function
REQ-013 SHALL implement the states IDLE, RUN, FINISH and DRAIN.
REQ-014 SHALL, in IDLE, ignore s_valid; when cfg_enable is 1, it SHALL latch cfg_len, clear the in-frame sample counter and enter RUN on the next cycle.
REQ-015 SHALL, in RUN, write every s_valid sample into the FIFO with a last bit, where last = (sample counter == latched length - 1); the counter SHALL wrap to 0 after the last sample.
REQ-016 SHALL, on cfg_enable = 0 in RUN, go to FINISH; FINISH SHALL keep writing until the last sample of the frame is written, then go to DRAIN. If the counter is 0 at that point, the transition SHALL go directly to DRAIN.
REQ-017 SHALL, on s_valid while the FIFO is full in RUN or FINISH, drop the sample, set overflow and go to DRAIN immediately; the partial frame already queued is output without tlast.
REQ-018 SHALL, in DRAIN, accept no writes and return to IDLE once the FIFO is empty and no output beat is pending.
REQ-019 SHALL present the FIFO output first-word-fall-through: a sample written at cycle n is visible on m_axis_tvalid no earlier than cycle n+1 and no later than cycle n+2 when the output is idle.
REQ-020 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-021 SHALL allow a simultaneous write and read with the FIFO full; in that case the write is accepted and no overflow occurs.
REQ-022 SHALL increment frame_count on each handshake (m_axis_tvalid and m_axis_tready both 1) with m_axis_tlast = 1.
REQ-023 SHALL ignore changes to cfg_len outside IDLE.

Reset
REQ-024 SHALL, on reset = 1, force: state IDLE, FIFO empty, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, overflow = 0, frame_count = 0, sample counter = 0.
REQ-025 SHALL give reset priority over all other inputs; a reset asserted mid-frame discards queued data with no tlast emitted.
REQ-026 SHALL clear overflow only by reset.

Configuration
REQ-027 SHALL add, when SAMPLE_FRAMER_TUSER_EN is defined, port m_axis_tuser (output, 1 bit), high on the first beat of each frame; the flag is stored in the FIFO alongside the data.
REQ-028 SHALL, when SAMPLE_FRAMER_TUSER_EN is undefined, have no tuser port or storage, with behaviour otherwise identical.

Structure
REQ-029 SHALL place the state encoding (IDLE, RUN, FINISH, DRAIN) and the default width constants in package sample_framer_pkg.
REQ-030 SHALL implement the FIFO as sub-module sample_fifo: synchronous, first-word-fall-through, with full and empty flags and a payload width parameter (data, last and optional tuser bits).

Verification
REQ-031 SHALL verify: cfg_len=4, cfg_enable=1, continuous s_valid with data 1..12, tready=1 -> 12 beats; tlast on 4, 8 and 12; frame_count=3.
REQ-032 SHALL verify: cfg_len=0 -> every beat has tlast; 5 samples -> frame_count=5.
REQ-033 SHALL verify: FIFO_DEPTH=16, tready=0, 17 samples -> overflow=1; then tready=1 -> exactly 16 beats, none with tlast; state returns to IDLE.
REQ-034 SHALL verify: cfg_len=8, cfg_enable dropped after sample 3 -> samples 4..8 still captured; tlast on 8; sample 9 is not captured.
REQ-035 SHALL verify: random tready at 50% duty, cfg_len=3, 300 samples -> data order preserved, 100 tlast beats, tdata stable while stalled.
REQ-036 SHALL verify: reset asserted mid-frame with 5 beats queued -> next cycle tvalid=0 and frame_count=0, and a fresh capture starts from sample index 0.
